// File: rtl/ovl_win_scheduler.sv
// Round-robin scheduler that time-shares one OVL-style window checker among
// several requesters: it grants one requester, frames its window with start/end pulses.
module ovl_win_scheduler #(
    parameter int width      = 8,
    parameter int num_req    = 4,
    parameter int max_window = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [num_req-1:0]       req,
    input  logic [num_req-1:0]       done,
    input  logic [num_req*width-1:0] test_bus,
    output logic [num_req-1:0]       gnt,
    output logic                     start_event,
    output logic                     end_event,
    output logic                     window,
    output logic [width-1:0]         test_expr,
    output logic                     timeout,
    output logic                     abort,
    output logic [15:0]              win_count
);

    localparam int IDX_W = (num_req > 1) ? $clog2(num_req) : 1;
    localparam int CNT_W = (max_window > 1) ? $clog2(max_window) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(max_window - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(num_req - 1);
    localparam logic [IDX_W:0]   NUM_REQ  = (IDX_W + 1)'(num_req);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [num_req-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 start_event_q, start_event_d;
    logic                 end_event_q, end_event_d;
    logic                 window_q, window_d;
    logic                 timeout_q, timeout_d;
    logic                 abort_q, abort_d;
    logic [15:0]          win_count_q, win_count_d;

    logic                 arb_found;
    logic [IDX_W-1:0]     arb_idx;
    logic [IDX_W:0]       arb_pos;
    logic [num_req-1:0]   arb_onehot;

    // Round-robin search: candidate (ptr + k) mod num_req, first set req bit wins.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_pos    = '0;
        arb_onehot = '0;
        for (int k = 0; k < num_req; k++) begin
            arb_pos = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (arb_pos >= NUM_REQ) begin
                arb_pos = arb_pos - NUM_REQ;
            end
            if (!arb_found && req[arb_pos[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_pos[IDX_W-1:0];
            end
        end
        arb_onehot[arb_idx] = arb_found;
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        idx_d         = idx_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        window_d      = window_q;
        win_count_d   = win_count_q;
        start_event_d = 1'b0;
        end_event_d   = 1'b0;
        timeout_d     = 1'b0;
        abort_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d       = START;
                    gnt_d         = arb_onehot;
                    idx_d         = arb_idx;
                    start_event_d = 1'b1;
                end
            end
            START: begin
                // done is deliberately not looked at here.
                state_d  = OPEN;
                window_d = 1'b1;
                cnt_d    = '0;
            end
            OPEN: begin
                if (done[idx_q]) begin
                    state_d     = CLOSE;
                    end_event_d = 1'b1;
                end else if (!req[idx_q]) begin
                    state_d     = CLOSE;
                    end_event_d = 1'b1;
                    abort_d     = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = CLOSE;
                    end_event_d = 1'b1;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLOSE: begin
                state_d     = IDLE;
                window_d    = 1'b0;
                gnt_d       = '0;
                ptr_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                win_count_d = (win_count_q == 16'hFFFF) ? win_count_q : win_count_q + 16'd1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset is asynchronous so an interrupted window vanishes without an end_event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            idx_q         <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            start_event_q <= 1'b0;
            end_event_q   <= 1'b0;
            window_q      <= 1'b0;
            timeout_q     <= 1'b0;
            abort_q       <= 1'b0;
            win_count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            idx_q         <= idx_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            start_event_q <= start_event_d;
            end_event_q   <= end_event_d;
            window_q      <= window_d;
            timeout_q     <= timeout_d;
            abort_q       <= abort_d;
            win_count_q   <= win_count_d;
        end
    end

    always_comb begin
        test_expr = '0;
        for (int i = 0; i < num_req; i++) begin
            if (gnt_q[i]) begin
                test_expr = test_bus[i*width +: width];
            end
        end
    end

    assign gnt         = gnt_q;
    assign start_event = start_event_q;
    assign end_event   = end_event_q;
    assign window      = window_q;
    assign timeout     = timeout_q;
    assign abort       = abort_q;
    assign win_count   = win_count_q;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
    a_no_start_end : assert property (@(posedge clk) disable iff (reset) !(start_event_q && end_event_q));
    a_no_to_abort : assert property (@(posedge clk) disable iff (reset) !(timeout_q && abort_q));

endmodule

// File: tb/tb_ovl_win_scheduler.sv
// Bench for ovl_win_scheduler: table of window scenarios, a scoreboard of expected
// close records, and a hand-written reset-mid-window sequence.
module tb_ovl_win_scheduler;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N*W-1:0] test_bus;
    logic [N-1:0]   gnt;
    logic           start_event;
    logic           end_event;
    logic           window;
    logic [W-1:0]   test_expr;
    logic           timeout;
    logic           abort;
    logic [15:0]    win_count;

    ovl_win_scheduler #(.width(W), .num_req(N), .max_window(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .test_bus   (test_bus),
        .gnt        (gnt),
        .start_event(start_event),
        .end_event  (end_event),
        .window     (window),
        .test_expr  (test_expr),
        .timeout    (timeout),
        .abort      (abort),
        .win_count  (win_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         bad_off;   // cycle offset from start_event of a pulse that must be ignored
        logic [3:0] bad_mask;
        int         done_off;  // offset at which done[granted] is pulsed (-1: never)
        int         drop_off;  // offset at which the granted req bit drops (-1: never)
        bit         noise;     // toggle req[2] every cycle of the window
        int         spacing;   // required start_event spacing from previous window (0: unchecked)
        logic [3:0] exp_gnt;
        bit         exp_to;
        bit         exp_ab;
        int         exp_open;  // open cycles before end_event
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        bit         to;
        bit         ab;
    } sb_t;

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   prev_start = -100;
    int   exp_wc     = 0;
    sb_t  exp_q[$];
    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [7:0] slice_of(input logic [3:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return test_bus[i*W +: W];
        end
        return 8'h00;
    endfunction

    task automatic run_window(input vec_t t, input int vi);
        bit   got_start;
        bit   got_end;
        bit   ok;
        int   open;
        sb_t  e;
        req       = t.req;
        done      = '0;
        got_start = 1'b0;
        for (int n = 0; n < 20 && !got_start; n++) begin
            tick();
            if (start_event) got_start = 1'b1;
        end
        check($sformatf("v%0d_start_seen", vi), int'(got_start), 1);
        if (!got_start) return;
        check($sformatf("v%0d_start_gnt", vi), int'(gnt), int'(t.exp_gnt));
        check($sformatf("v%0d_start_window", vi), int'(window), 0);
        if (t.spacing > 0) check($sformatf("v%0d_spacing", vi), cyc - prev_start, t.spacing);
        prev_start = cyc;
        exp_q.push_back('{gnt: t.exp_gnt, to: t.exp_to, ab: t.exp_ab});

        open    = 0;
        ok      = 1'b1;
        got_end = 1'b0;
        for (int off = 0; off < 300 && !got_end; off++) begin
            done = '0;
            if (off == t.bad_off)  done = done | t.bad_mask;
            if (off == t.done_off) done = done | t.exp_gnt;
            if (off == t.drop_off) req = t.req & ~t.exp_gnt;
            if (t.noise)           req = req ^ 4'b0100;
            tick();
            if (end_event) begin
                got_end = 1'b1;
            end else begin
                if (window) open++;
                if (!window || start_event || timeout || abort) ok = 1'b0;
            end
            if (gnt !== t.exp_gnt || test_expr !== slice_of(t.exp_gnt)) ok = 1'b0;
        end
        done = '0;
        check($sformatf("v%0d_end_seen", vi), int'(got_end), 1);
        if (!got_end) return;

        if (exp_q.size() == 0) begin
            check($sformatf("v%0d_sb_nonempty", vi), 0, 1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d_end_gnt", vi), int'(gnt), int'(e.gnt));
            check($sformatf("v%0d_timeout", vi), int'(timeout), int'(e.to));
            check($sformatf("v%0d_abort", vi), int'(abort), int'(e.ab));
        end
        check($sformatf("v%0d_close_window", vi), int'(window), 1);
        check($sformatf("v%0d_open_cycles", vi), open, t.exp_open);
        check($sformatf("v%0d_window_stable", vi), int'(ok), 1);

        tick();
        exp_wc++;
        check($sformatf("v%0d_idle_gnt", vi), int'(gnt), 0);
        check($sformatf("v%0d_idle_window", vi), int'(window), 0);
        check($sformatf("v%0d_idle_end", vi), int'(end_event | timeout | abort), 0);
        check($sformatf("v%0d_idle_texpr", vi), int'(test_expr), 0);
        check($sformatf("v%0d_win_count", vi), int'(win_count), exp_wc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t rv;
        bit   got;
        //          req      bad bmask    done drop nz sp  gnt      to    ab    open
        tbl[0] = '{4'b0101, -1, 4'b0000,  2,  -1,  0, 0, 4'b0001, 1'b0, 1'b0,  2};
        tbl[1] = '{4'b0101, -1, 4'b0000,  2,  -1,  0, 5, 4'b0100, 1'b0, 1'b0,  2};
        tbl[2] = '{4'b0101, -1, 4'b0000,  2,  -1,  0, 5, 4'b0001, 1'b0, 1'b0,  2};
        tbl[3] = '{4'b0010, -1, 4'b0000, -1,  -1,  0, 0, 4'b0010, 1'b1, 1'b0, 16};
        tbl[4] = '{4'b0100, -1, 4'b0000, -1,   3,  0, 0, 4'b0100, 1'b0, 1'b1,  3};
        tbl[5] = '{4'b1000, -1, 4'b0000, 16,  -1,  0, 0, 4'b1000, 1'b0, 1'b0, 16};
        tbl[6] = '{4'b0001,  2, 4'b1000,  5,  -1,  1, 0, 4'b0001, 1'b0, 1'b0,  5};
        tbl[7] = '{4'b0010,  0, 4'b0010,  3,  -1,  0, 0, 4'b0010, 1'b0, 1'b0,  3};
        tbl[8] = '{4'b1100, -1, 4'b0000,  1,  -1,  0, 0, 4'b0100, 1'b0, 1'b0,  1};
        tbl[9] = '{4'b1100, -1, 4'b0000,  1,  -1,  0, 4, 4'b1000, 1'b0, 1'b0,  1};

        reset    = 1'b1;
        req      = 4'b1111;
        done     = '0;
        test_bus = '0;
        tick();
        tick();
        tick();
        check("rst_gnt", int'(gnt), 0);
        check("rst_pulses", int'({start_event, end_event, timeout, abort}), 0);
        check("rst_window", int'(window), 0);
        check("rst_win_count", int'(win_count), 0);
        check("rst_texpr", int'(test_expr), 0);

        req   = '0;
        reset = 1'b0;
        tick();
        tick();
        check("idle_no_req", int'({start_event, gnt}), 0);

        for (int v = 0; v < 10; v++) begin
            test_bus = {$urandom};
            if (v == 6) test_bus[7:0] = 8'hA5;
            run_window(tbl[v], v);
        end

        // Reset in the middle of a window granted to requester 3.
        req = 4'b1000;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            if (start_event) got = 1'b1;
        end
        check("mid_start_gnt", int'(gnt), 4'b1000);
        tick();
        tick();
        check("mid_open_window", int'(window), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_window", int'(window), 0);
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_win_count", int'(win_count), 0);
        check("mid_rst_pulses", int'({start_event, end_event, timeout, abort}), 0);
        tick();
        check("mid_rst_held", int'({end_event, window, gnt}), 0);
        reset      = 1'b0;
        exp_wc     = 0;
        prev_start = cyc;
        rv = '{4'b1001, -1, 4'b0000, 2, -1, 0, 1, 4'b0001, 1'b0, 1'b0, 2};
        run_window(rv, 10);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ovl_win_scheduler.md
OVL_WIN_SCHEDULER -- requirements
Module: ovl_win_scheduler

Interface
REQ-001 Parameter width, default 8: bit width of each requester's test expression.
REQ-002 Parameter num_req, default 4: number of requesters sharing the window checker (range 2..8).
REQ-003 Parameter max_window, default 16: maximum OPEN cycles before forced close (range 2..256).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  num_req  level request per requester to own the shared window.
REQ-007 done  input  num_req  per-requester window-close request; only the granted bit is honoured.
REQ-008 test_bus  input  num_req*width  concatenated test expressions; requester i occupies bits [i*width +: width].
REQ-009 gnt  output  num_req  one-hot grant, or zero when no grant is active.
REQ-010 start_event  output  1  one-cycle pulse that opens the shared checker window.
REQ-011 end_event  output  1  one-cycle pulse that closes the shared checker window.
REQ-012 window  output  1  high while the checker window is open.
REQ-013 test_expr  output  width  test_bus slice of the granted requester; zero when gnt is zero.
REQ-014 timeout  output  1  one-cycle pulse, coincident with end_event, on a forced close.
REQ-015 abort  output  1  one-cycle pulse, coincident with end_event, when the granted req drops mid-window.
REQ-016 win_count  output  16  number of completed windows; saturates at 16'hFFFF.

Function
REQ-017 FSM states SHALL be IDLE, START, OPEN and CLOSE; all outputs except test_expr SHALL be registered.
REQ-018 IDLE: when req is nonzero, next state START; gnt loads the one-hot winner; start_event=1.
REQ-019 Arbitration SHALL be round-robin: search starts at index ptr and wraps modulo num_req; the first set req bit wins.
REQ-020 START lasts exactly one cycle; next state OPEN; window=1; start_event=0; cnt=0.
REQ-021 OPEN: cnt SHALL increment every cycle; width SHALL be clog2(max_window), with no wrap, because the state exits at max_window-1.
REQ-022 OPEN exit: if done[idx]=1, next state CLOSE with end_event=1.
REQ-023 OPEN exit: else if req[idx]=0, next state CLOSE with end_event=1 and abort=1.
REQ-024 OPEN exit: else if cnt==max_window-1, next state CLOSE with end_event=1 and timeout=1.
REQ-025 Priority SHALL be done > abort > timeout; at most one of timeout and abort is asserted.
REQ-026 CLOSE lasts exactly one cycle; window stays 1 during CLOSE.
REQ-027 On the CLOSE->IDLE transition: window=0, gnt=0, end_event/timeout/abort=0, ptr=(idx+1) mod num_req, win_count increments (saturating).
REQ-028 At least one IDLE cycle SHALL separate consecutive windows.
REQ-029 The minimum start_event-to-start_event spacing SHALL be 4 cycles.
REQ-030 done bits of non-granted requesters SHALL be ignored.
REQ-031 done asserted during START SHALL be ignored.
REQ-032 req changes of non-granted requesters SHALL not affect the active window.
REQ-033 test_expr SHALL be a combinational mux of test_bus selected by gnt.
REQ-034 start_event and end_event SHALL never be asserted in the same cycle.
REQ-035 gnt SHALL be constant from START through CLOSE inclusive.

Reset
REQ-036 On reset assertion, at any time including mid-window: state=IDLE, gnt=0, start_event=0, end_event=0, window=0, timeout=0, abort=0, cnt=0, ptr=0, win_count=0; this takes effect immediately, not at the next clock.
REQ-037 On reset deassertion, the first grant SHALL be evaluated at the next rising edge with ptr=0.
REQ-038 A window interrupted by reset SHALL produce no end_event and SHALL not be counted.

Verification
REQ-039 req=4'b0101 held, each done pulsed 2 cycles after start_event -> grants alternate 0001,0100,0001; start_event every 5 cycles; win_count=3 after 3 windows.
REQ-040 req=4'b0010, done never asserted -> end_event and timeout both pulse on the 16th OPEN cycle; gnt=0 the following cycle; win_count=1.
REQ-041 req[2] granted, then dropped on OPEN cycle 3 -> abort=1 and end_event=1 on the next cycle; timeout=0.
REQ-042 done[idx]=1 on the same cycle cnt==15 -> end_event=1, timeout=0.
REQ-043 reset asserted during OPEN with gnt=4'b1000 -> window, gnt and win_count=0 before the next edge; after release, req=4'b1001 grants 0001 first.
REQ-044 done[3] pulsed while gnt=4'b0001 and test_bus slice 0=8'hA5 -> no close; test_expr=8'hA5 throughout the window.
